// File: rtl/rf_write_arbiter_if.sv
// Write-port bundle between the two writeback requesters, the decoder and the register file.
// Latency: none; wiring only.
// Backpressure: each requester holds valid until it sees its ready; stall throttles the decoder.
interface rf_write_arbiter_if #(
  parameter int WORD_LENGTH = 8,
  parameter int REG_ADDR_W  = 2
);
  logic                   hold;
  logic                   req0_valid;
  logic [REG_ADDR_W-1:0]  req0_reg;
  logic [WORD_LENGTH-1:0] req0_data;
  logic                   req0_ready;
  logic                   req1_valid;
  logic [REG_ADDR_W-1:0]  req1_reg;
  logic [WORD_LENGTH-1:0] req1_data;
  logic                   req1_ready;
  logic [REG_ADDR_W-1:0]  write_reg;
  logic [WORD_LENGTH-1:0] write_data;
  logic                   write_reg_en;
  logic                   rd_valid;
  logic [REG_ADDR_W-1:0]  read_reg1;
  logic [REG_ADDR_W-1:0]  read_reg2;
  logic                   stall;
  logic                   last_grant;

  // Requester/decoder side: drives requests and reads, observes grants and the write port.
  modport master (
    output hold, req0_valid, req0_reg, req0_data, req1_valid, req1_reg, req1_data,
    output rd_valid, read_reg1, read_reg2,
    input  req0_ready, req1_ready, write_reg, write_data, write_reg_en, stall, last_grant
  );

  // Arbiter side.
  modport slave (
    input  hold, req0_valid, req0_reg, req0_data, req1_valid, req1_reg, req1_data,
    input  rd_valid, read_reg1, read_reg2,
    output req0_ready, req1_ready, write_reg, write_data, write_reg_en, stall, last_grant
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between ALU and load writeback.
// Latency: a grant in cycle N drives write_* in cycle N+1; one write per cycle.
// Backpressure: ready is combinational per requester; hold blocks all grants; stall flags read-after-write hazards.
module rf_write_arbiter #(
  parameter int WORD_LENGTH = 8,
  parameter int REG_ADDR_W  = 2
) (
  input logic              clk,
  input logic              rst,
  rf_write_arbiter_if.slave bus
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0]  rg;
    logic [WORD_LENGTH-1:0] dat;
  } wr_t;

  wr_t  wr_q;
  wr_t  wr_sel;
  logic wr_en_q;
  logic last_grant_q;
  logic grant0;
  logic grant1;

  // Pick the winner: a lone requester wins, on contention the one not granted last time wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && !bus.hold) begin
      grant0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
      grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
    end
    wr_sel = grant1 ? wr_t'{rg: bus.req1_reg, dat: bus.req1_data}
                    : wr_t'{rg: bus.req0_reg, dat: bus.req0_data};
  end

  // Register the granted write; the enable is a one-cycle pulse, address/data hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q         <= '0;
      wr_en_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (grant0 || grant1) begin
      wr_q         <= wr_sel;
      wr_en_q      <= 1'b1;
      last_grant_q <= grant1;
    end else begin
      wr_en_q      <= 1'b0;
    end
  end

  assign bus.req0_ready   = grant0;
  assign bus.req1_ready   = grant1;
  assign bus.write_reg    = wr_q.rg;
  assign bus.write_data   = wr_q.dat;
  assign bus.write_reg_en = wr_en_q;
  assign bus.last_grant   = last_grant_q;
  // The write on the port this cycle is not yet visible to readers, so a matching source must wait one cycle.
  assign bus.stall        = !rst && bus.rd_valid && wr_en_q &&
                            (wr_q.rg == bus.read_reg1 || wr_q.rg == bus.read_reg2);

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  rf_write_arbiter_if #(.WORD_LENGTH(8), .REG_ADDR_W(2)) bus ();

  rf_write_arbiter #(.WORD_LENGTH(8), .REG_ADDR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic clear_inputs();
    bus.hold = 0; bus.rd_valid = 0; bus.read_reg1 = 0; bus.read_reg2 = 0;
    bus.req0_valid = 0; bus.req0_reg = 0; bus.req0_data = 0;
    bus.req1_valid = 0; bus.req1_reg = 0; bus.req1_data = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    @(negedge clk);
    bus.req0_valid = 1; bus.req1_valid = 1; bus.rd_valid = 1;
    @(posedge clk);
    #1;
    tests++; if (bus.write_reg_en !== 1'b0) begin fails++; $display("FAIL reset_en: got %b want 0", bus.write_reg_en); end
    tests++; if (bus.write_reg !== 2'd0) begin fails++; $display("FAIL reset_reg: got %0d want 0", bus.write_reg); end
    tests++; if (bus.write_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", bus.write_data); end
    tests++; if (bus.last_grant !== 1'b1) begin fails++; $display("FAIL reset_last_grant: got %b want 1", bus.last_grant); end
    tests++; if (bus.req0_ready !== 1'b0) begin fails++; $display("FAIL reset_ready0: got %b want 0", bus.req0_ready); end
    tests++; if (bus.req1_ready !== 1'b0) begin fails++; $display("FAIL reset_ready1: got %b want 0", bus.req1_ready); end
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
    clear_inputs();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_single();
    do_reset();
    bus.req0_valid = 1; bus.req0_reg = 2; bus.req0_data = 8'h5A;
    #1;
    tests++; if (bus.req0_ready !== 1'b1) begin fails++; $display("FAIL single_ready0: got %b want 1", bus.req0_ready); end
    tests++; if (bus.req1_ready !== 1'b0) begin fails++; $display("FAIL single_ready1: got %b want 0", bus.req1_ready); end
    @(negedge clk);
    bus.req0_valid = 0;
    tests++; if (bus.write_reg_en !== 1'b1 || bus.write_reg !== 2'd2 || bus.write_data !== 8'h5A)
      begin fails++; $display("FAIL single_write: got en=%b reg=%0d data=%h want en=1 reg=2 data=5a", bus.write_reg_en, bus.write_reg, bus.write_data); end
    tests++; if (bus.last_grant !== 1'b0) begin fails++; $display("FAIL single_last_grant: got %b want 0", bus.last_grant); end
    @(negedge clk);
    tests++; if (bus.write_reg_en !== 1'b0 || bus.write_reg !== 2'd2 || bus.write_data !== 8'h5A)
      begin fails++; $display("FAIL single_idle: got en=%b reg=%0d data=%h want en=0 reg=2 data=5a", bus.write_reg_en, bus.write_reg, bus.write_data); end
  endtask

  task automatic test_alternate();
    logic [1:0] er;
    logic [7:0] ed;
    do_reset();
    bus.req0_valid = 1; bus.req0_reg = 1; bus.req0_data = 8'h11;
    bus.req1_valid = 1; bus.req1_reg = 3; bus.req1_data = 8'h33;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (bus.req0_ready !== (i % 2 == 0) || bus.req1_ready !== (i % 2 == 1))
        begin fails++; $display("FAIL alt_grant[%0d]: got r0=%b r1=%b want r0=%b r1=%b", i, bus.req0_ready, bus.req1_ready, i % 2 == 0, i % 2 == 1); end
      er = (i % 2 == 0) ? 2'd1 : 2'd3;
      ed = (i % 2 == 0) ? 8'h11 : 8'h33;
      @(negedge clk);
      tests++; if (bus.write_reg_en !== 1'b1 || bus.write_reg !== er || bus.write_data !== ed)
        begin fails++; $display("FAIL alt_write[%0d]: got en=%b reg=%0d data=%h want en=1 reg=%0d data=%h", i, bus.write_reg_en, bus.write_reg, bus.write_data, er, ed); end
    end
    clear_inputs();
  endtask

  task automatic test_same_dest();
    logic [7:0] rf0;
    rf0 = 8'h00;
    do_reset();
    bus.req0_valid = 1; bus.req0_reg = 0; bus.req0_data = 8'hAA;
    bus.req1_valid = 1; bus.req1_reg = 0; bus.req1_data = 8'hBB;
    @(negedge clk);
    if (bus.write_reg_en === 1'b1 && bus.write_reg === 2'd0) rf0 = bus.write_data;
    tests++; if (rf0 !== 8'hAA) begin fails++; $display("FAIL same_first: got %h want aa", rf0); end
    bus.req0_valid = 0;
    @(negedge clk);
    if (bus.write_reg_en === 1'b1 && bus.write_reg === 2'd0) rf0 = bus.write_data;
    bus.req1_valid = 0;
    tests++; if (rf0 !== 8'hBB) begin fails++; $display("FAIL same_final: got %h want bb", rf0); end
    tests++; if (bus.last_grant !== 1'b1) begin fails++; $display("FAIL same_last_grant: got %b want 1", bus.last_grant); end
  endtask

  task automatic test_hold();
    do_reset();
    bus.hold = 1;
    bus.req1_valid = 1; bus.req1_reg = 3; bus.req1_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (bus.req1_ready !== 1'b0) begin fails++; $display("FAIL hold_ready[%0d]: got %b want 0", i, bus.req1_ready); end
      @(negedge clk);
      tests++; if (bus.write_reg_en !== 1'b0) begin fails++; $display("FAIL hold_en[%0d]: got %b want 0", i, bus.write_reg_en); end
    end
    bus.hold = 0;
    #1;
    tests++; if (bus.req1_ready !== 1'b1) begin fails++; $display("FAIL hold_release_ready: got %b want 1", bus.req1_ready); end
    @(negedge clk);
    bus.req1_valid = 0;
    bus.hold = 1;
    tests++; if (bus.write_reg_en !== 1'b1 || bus.write_reg !== 2'd3 || bus.write_data !== 8'h77)
      begin fails++; $display("FAIL hold_write: got en=%b reg=%0d data=%h want en=1 reg=3 data=77", bus.write_reg_en, bus.write_reg, bus.write_data); end
    tests++; if (bus.last_grant !== 1'b1) begin fails++; $display("FAIL hold_last_grant: got %b want 1", bus.last_grant); end
    clear_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    bus.req0_valid = 1; bus.req0_reg = 2; bus.req0_data = 8'h42;
    @(negedge clk);
    bus.req0_valid = 0;
    bus.rd_valid = 1; bus.read_reg1 = 2; bus.read_reg2 = 0;
    #1;
    tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL stall_src1: got %b want 1", bus.stall); end
    bus.read_reg1 = 1; bus.read_reg2 = 3;
    #1;
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL stall_nomatch: got %b want 0", bus.stall); end
    bus.read_reg1 = 0; bus.read_reg2 = 2;
    #1;
    tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL stall_src2: got %b want 1", bus.stall); end
    bus.rd_valid = 0;
    #1;
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL stall_no_rd: got %b want 0", bus.stall); end
    @(negedge clk);
    bus.rd_valid = 1;
    #1;
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL stall_after_commit: got %b want 0", bus.stall); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req0_valid = 1; bus.req0_reg = 1; bus.req0_data = 8'h11;
    bus.req1_valid = 1; bus.req1_reg = 3; bus.req1_data = 8'h33;
    @(negedge clk);
    bus.req0_valid = 0;
    #1;
    rst = 1;
    #1;
    tests++; if (bus.write_reg_en !== 1'b0) begin fails++; $display("FAIL rstmid_en: got %b want 0", bus.write_reg_en); end
    tests++; if (bus.last_grant !== 1'b1) begin fails++; $display("FAIL rstmid_last_grant: got %b want 1", bus.last_grant); end
    tests++; if (bus.req1_ready !== 1'b0) begin fails++; $display("FAIL rstmid_ready1: got %b want 0", bus.req1_ready); end
    @(negedge clk);
    rst = 0;
    bus.req0_valid = 1;
    #1;
    tests++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
      begin fails++; $display("FAIL rstmid_first: got r0=%b r1=%b want r0=1 r1=0", bus.req0_ready, bus.req1_ready); end
    @(negedge clk);
    tests++; if (bus.write_reg_en !== 1'b1 || bus.write_reg !== 2'd1 || bus.write_data !== 8'h11)
      begin fails++; $display("FAIL rstmid_write: got en=%b reg=%0d data=%h want en=1 reg=1 data=11", bus.write_reg_en, bus.write_reg, bus.write_data); end
    clear_inputs();
  endtask

  // Reference model: pending requests per requester, round-robin pointer, and the write currently on the port.
  task automatic test_random();
    logic       pv [2];
    logic [1:0] pr [2];
    logic [7:0] pd [2];
    logic       m_last, m_en;
    logic [1:0] m_reg;
    logic [7:0] m_data;
    logic       m_stall;
    int         winner;
    do_reset();
    pv = '{0, 0}; pr = '{0, 0}; pd = '{0, 0};
    m_last = 1; m_en = 0; m_reg = 0; m_data = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tests++; if (bus.write_reg_en !== m_en || bus.last_grant !== m_last || (m_en && (bus.write_reg !== m_reg || bus.write_data !== m_data)))
        begin fails++; $display("FAIL rand_write[%0d]: got en=%b reg=%0d data=%h lg=%b want en=%b reg=%0d data=%h lg=%b", cyc, bus.write_reg_en, bus.write_reg, bus.write_data, bus.last_grant, m_en, m_reg, m_data, m_last); end
      for (int r = 0; r < 2; r++) begin
        if (!pv[r] && $urandom_range(0, 2) != 0) begin
          pv[r] = 1; pr[r] = 2'($urandom_range(0, 3)); pd[r] = 8'($urandom);
        end
      end
      bus.req0_valid = pv[0]; bus.req0_reg = pr[0]; bus.req0_data = pd[0];
      bus.req1_valid = pv[1]; bus.req1_reg = pr[1]; bus.req1_data = pd[1];
      bus.hold = ($urandom_range(0, 4) == 0);
      bus.rd_valid = 1'($urandom);
      bus.read_reg1 = 2'($urandom_range(0, 3));
      bus.read_reg2 = 2'($urandom_range(0, 3));
      if (bus.hold) winner = -1;
      else if (pv[0] && pv[1]) winner = m_last ? 0 : 1;
      else if (pv[0]) winner = 0;
      else if (pv[1]) winner = 1;
      else winner = -1;
      m_stall = bus.rd_valid && m_en && (m_reg == bus.read_reg1 || m_reg == bus.read_reg2);
      #1;
      tests++; if (bus.req0_ready !== (winner == 0) || bus.req1_ready !== (winner == 1))
        begin fails++; $display("FAIL rand_grant[%0d]: got r0=%b r1=%b want winner %0d", cyc, bus.req0_ready, bus.req1_ready, winner); end
      tests++; if (bus.stall !== m_stall)
        begin fails++; $display("FAIL rand_stall[%0d]: got %b want %b", cyc, bus.stall, m_stall); end
      @(negedge clk);
      if (winner >= 0) begin
        m_en = 1; m_reg = pr[winner]; m_data = pd[winner]; m_last = (winner == 1); pv[winner] = 0;
      end else begin
        m_en = 0;
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_alternate();
    test_same_dest();
    test_hold();
    test_stall();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
